// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
// Processor-side issue controller for an iterative multiply/divide unit.
// Accepts a MULT or DIV from execute and freezes the pipeline. It then
// strobes the unit for one cycle and holds the operands while the unit
// iterates. It waits for result-ready, with a timeout, and performs a single
// register-file writeback. That writeback is either the result or an
// exception code written to the status register.
//
// Ports
//   clock, reset        : rising-edge clock, async active-high reset
//   issue_*             : instruction presented by the execute stage
//   ctrl_MULT/ctrl_DIV  : one-cycle start strobes to the unit
//   data_operandA/B     : held operands to the unit
//   data_result/exception/resultRDY : completion handshake from the unit
//   stall, busy         : pipeline freeze / controller occupied
//   wb_valid/reg/data   : one-cycle register-file write
//
// state  | meaning
// IDLE   | no operation in flight
// START  | start strobe to the unit this cycle
// WAIT   | unit iterating; counting toward timeout
// WB     | writeback cycle; may accept the next operation

module multdiv_issue_ctrl #(
  parameter int TIMEOUT       = 64,
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_WB} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_op;      // 0 = MULT, 1 = DIV
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [4:0]    r_rd;
  logic [31:0]   r_res;
  logic          r_exc;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_timeout;

  // Only IDLE and WB may take a new instruction; WB overlaps the next issue.
  assign w_accept  = issue_valid & (issue_mult | issue_div) &
                     ((r_state == S_IDLE) | (r_state == S_WB));
  assign w_timeout = (r_cnt == TC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op  <= 1'b0;
      r_opA <= '0;
      r_opB <= '0;
      r_rd  <= '0;
      r_res <= '0;
      r_exc <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= ~issue_mult;  // MULT wins if both are flagged
        r_opA <= issue_opA;
        r_opB <= issue_opB;
        r_rd  <= issue_rd;
      end
      case (r_state)
        S_START: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (data_resultRDY) begin
            r_res <= data_result;
            r_exc <= data_exception;
          end else if (w_timeout) begin
            r_exc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        ctrl_MULT = ~r_op;
        ctrl_DIV  = r_op;
        stall     = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (data_resultRDY || w_timeout) w_next = S_WB;
      end
      S_WB: begin
        // stall stays low so the next instruction advances alongside the write
        if (r_exc) begin
          wb_valid = 1'b1;
          wb_reg   = 5'(RSTATUS_REG);
          wb_data  = r_op ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
        end else begin
          wb_valid = (r_rd != 5'd0);
          wb_reg   = r_rd;
          wb_data  = r_res;
        end
        w_next = w_accept ? S_START : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy          = (r_state != S_IDLE);
  assign data_operandA = r_opA;
  assign data_operandB = r_opB;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Testbench for multdiv_issue_ctrl. The bench plays the multiply/divide unit.
// It computes each expected writeback from the operation's arithmetic
// meaning, the chosen ready latency and the timeout rule. A second instance
// with a short timeout exercises the forced-exception path.

module tb_multdiv_issue_ctrl;

  localparam int TO_MAIN = 64;
  localparam int TO_SHORT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_mult, issue_div;
  logic [31:0] issue_opA, issue_opB;
  logic [4:0]  issue_rd;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid;
  logic [31:0] data_operandA, data_operandB, wb_data;
  logic [4:0]  wb_reg;

  logic        t_valid;
  logic        t_rdy = 1'b0;
  logic        t_ctrl_MULT, t_ctrl_DIV, t_stall, t_busy, t_wb_valid;
  logic [31:0] t_opA, t_opB, t_wb_data;
  logic [4:0]  t_wb_reg;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_mult(issue_mult), .issue_div(issue_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  multdiv_issue_ctrl #(.TIMEOUT(TO_SHORT)) dut_t (
    .clock(clock), .reset(reset),
    .issue_valid(t_valid), .issue_mult(issue_mult), .issue_div(issue_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .ctrl_MULT(t_ctrl_MULT), .ctrl_DIV(t_ctrl_DIV),
    .data_operandA(t_opA), .data_operandB(t_opB),
    .data_result(32'd0), .data_exception(1'b0),
    .data_resultRDY(t_rdy),
    .stall(t_stall), .busy(t_busy),
    .wb_valid(t_wb_valid), .wb_reg(t_wb_reg), .wb_data(t_wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic scramble_issue();
    issue_opA = $urandom;
    issue_opB = $urandom;
    issue_rd  = 5'($urandom);
  endtask

  // One operation from the accept cycle through its WB cycle. The task
  // returns at the WB sampling point, so a following call may chain from WB.
  // lat = WAIT-cycle index at which ready arrives; negative = never.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input bit from_wb,
                        input bit spur);
    logic [31:0] res, exp_data;
    logic [4:0]  exp_reg;
    bit          exc, exp_v, timed_out;
    exc = 1'b0;
    if (!is_div) res = a * b;
    else if (b == 32'd0) begin res = 32'd0; exc = 1'b1; end
    else res = $signed(a) / $signed(b);
    timed_out = (lat < 0) || (lat > TO_MAIN - 1);
    if (timed_out || exc) begin
      exp_v = 1'b1; exp_reg = 5'd30; exp_data = is_div ? 32'd5 : 32'd4;
    end else begin
      exp_v = (rd != 5'd0); exp_reg = rd; exp_data = res;
    end

    issue_valid = 1'b1; issue_mult = !is_div; issue_div = is_div;
    issue_opA = a; issue_opB = b; issue_rd = rd;
    #1;
    chk("accept_stall", stall, !from_wb);

    @(posedge clock); @(negedge clock);
    issue_valid = 1'b0; issue_mult = 1'($urandom); issue_div = 1'($urandom);
    scramble_issue();
    data_resultRDY = spur; data_result = $urandom; data_exception = 1'($urandom);
    #1;
    chk("start_mult", ctrl_MULT, !is_div);
    chk("start_div", ctrl_DIV, is_div);
    chk("start_stall", stall, 1);
    chk("start_busy", busy, 1);
    chk("start_opA", data_operandA, a);
    chk("start_opB", data_operandB, b);
    chk("start_wbv", wb_valid, 0);

    for (int k = 0; k < TO_MAIN; k++) begin
      @(posedge clock); @(negedge clock);
      data_resultRDY = (k == lat);
      data_result    = (k == lat) ? res : $urandom;
      data_exception = (k == lat) ? exc : 1'($urandom);
      scramble_issue();
      #1;
      chk("wait_strobe", {ctrl_MULT, ctrl_DIV}, 0);
      chk("wait_stall", stall, 1);
      chk("wait_opA", data_operandA, a);
      chk("wait_opB", data_operandB, b);
      chk("wait_wbv", wb_valid, 0);
      if (k == lat) break;
    end

    @(posedge clock); @(negedge clock);
    data_resultRDY = 1'b0; data_exception = 1'b0;
    #1;
    chk("wb_valid", wb_valid, exp_v);
    chk("wb_reg", wb_reg, exp_reg);
    chk("wb_data", wb_data, exp_data);
    chk("wb_stall", stall, 0);
    chk("wb_busy", busy, 1);
  endtask

  task automatic idle_check();
    @(posedge clock); @(negedge clock);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_wbv", wb_valid, 0);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    int   tcyc;
    bit   chain;
    bit   r_div;
    logic [31:0] ra, rb;

    reset = 1'b1; issue_valid = 0; t_valid = 0; issue_mult = 0; issue_div = 0;
    issue_opA = 0; issue_opB = 0; issue_rd = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    #1;
    chk("rst_mult", ctrl_MULT, 0);
    chk("rst_div", ctrl_DIV, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb", {wb_valid, wb_reg}, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_opA", data_operandA, 0);
    chk("rst_opB", data_operandB, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    // MULT basic: ready 33 cycles after the strobe
    run_op(0, 32'd7, -32'sd6, 5'd3, 32, 0, 0);
    idle_check();
    // DIV by zero -> exception writeback
    run_op(1, 32'd10, 32'd0, 5'd5, 4, 0, 0);
    idle_check();

    // Short-timeout instance: ready never comes, WB 10 cycles after accept
    @(negedge clock);
    t_valid = 1'b1; issue_mult = 1'b1; issue_div = 1'b0; issue_rd = 5'd4;
    tcyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); @(negedge clock);
      t_valid = 1'b0;
      #1;
      if (t_wb_valid) begin
        tcyc = c;
        break;
      end
    end
    chk("to_cycle", tcyc, TO_SHORT + 2);
    chk("to_reg", t_wb_reg, 30);
    chk("to_data", t_wb_data, 4);

    // Back-to-back from WB with a stale ready in START
    @(negedge clock);
    run_op(1, 32'd100, 32'd7, 5'd2, 6, 0, 0);
    run_op(0, 32'd3, 32'd3, 5'd2, 2, 1, 1);
    idle_check();

    // Reset five cycles into WAIT; the late ready must not write back
    @(negedge clock);
    issue_valid = 1'b1; issue_mult = 1'b1; issue_div = 1'b0;
    issue_opA = 32'd5; issue_opB = 32'd6; issue_rd = 5'd7;
    @(posedge clock); @(negedge clock);
    issue_valid = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    chk("mid_rst_opA", data_operandA, 0);
    chk("mid_rst_opB", data_operandB, 0);
    chk("mid_rst_wb", {wb_valid, wb_reg}, 0);
    chk("mid_rst_wbdata", wb_data, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); data_resultRDY = 1'b1; data_result = 32'd30;
    @(negedge clock); data_resultRDY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      chk("late_rdy_wbv", wb_valid, 0);
      chk("late_rdy_busy", busy, 0);
    end

    // rd = 0 without exception: no write
    run_op(0, 32'd11, 32'd13, 5'd0, 3, 0, 0);
    idle_check();
    // Full-length timeout on the default instance
    run_op(0, 32'd2, 32'd9, 5'd8, -1, 0, 0);
    idle_check();

    // Randomized operations, sometimes chained directly from WB
    chain = 1'b0;
    for (int i = 0; i < 12; i++) begin
      r_div = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (rb == 32'hFFFF_FFFF) rb = 32'd1;
      run_op(r_div, ra, rb, 5'($urandom), int'($urandom_range(0, 20)), chain,
             1'($urandom));
      chain = 1'($urandom);
      if (!chain) idle_check();
    end
    if (chain) idle_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
